// File: rtl/chain_code_pkg.sv
// Shared Freeman chain-code definitions: direction codes, decoder states and
// the per-direction unit step used by both the encoder and the decoder.
package chain_code_pkg;

   localparam logic [2:0] DIR_E  = 3'd0;
   localparam logic [2:0] DIR_NE = 3'd1;
   localparam logic [2:0] DIR_N  = 3'd2;
   localparam logic [2:0] DIR_NW = 3'd3;
   localparam logic [2:0] DIR_W  = 3'd4;
   localparam logic [2:0] DIR_SW = 3'd5;
   localparam logic [2:0] DIR_S  = 3'd6;
   localparam logic [2:0] DIR_SE = 3'd7;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      PLOT,
      RUN,
      FIN
   } state_t;

   function automatic logic signed [1:0] dir_dx(input logic [2:0] code);
      case (code)
         DIR_E, DIR_NE, DIR_SE: dir_dx = 2'sd1;
         DIR_NW, DIR_W, DIR_SW: dir_dx = -2'sd1;
         default:               dir_dx = 2'sd0;
      endcase
   endfunction

   // y grows downward, so "north" is a negative step
   function automatic logic signed [1:0] dir_dy(input logic [2:0] code);
      case (code)
         DIR_NE, DIR_N, DIR_NW: dir_dy = -2'sd1;
         DIR_SW, DIR_S, DIR_SE: dir_dy = 2'sd1;
         default:               dir_dy = 2'sd0;
      endcase
   endfunction

endpackage

// File: rtl/chain_code_step.sv
// One chain-code step: next pixel coordinates from (x, y, code) plus a flag
// telling whether that pixel falls outside the image.
module chain_code_step
   import chain_code_pkg::*;
#(
   parameter int IMG_W = 64,
   parameter int IMG_H = 64,
   parameter int XW    = $clog2(IMG_W),
   parameter int YW    = $clog2(IMG_H)
) (
   input  logic [XW-1:0] x,
   input  logic [YW-1:0] y,
   input  logic [2:0]    code,
   output logic [XW-1:0] next_x,
   output logic [YW-1:0] next_y,
   output logic          oob
);

   logic signed [XW:0] sx;
   logic signed [YW:0] sy;

   // One extra bit turns a step below zero into a visible sign bit
   always_comb begin
      sx     = $signed({1'b0, x}) + (XW+1)'(dir_dx(code));
      sy     = $signed({1'b0, y}) + (YW+1)'(dir_dy(code));
      next_x = sx[XW-1:0];
      next_y = sy[YW-1:0];
      oob    = sx[XW] || sy[YW]
               || (32'(sx[XW-1:0]) >= IMG_W)
               || (32'(sy[YW-1:0]) >= IMG_H);
   end

endmodule

// File: rtl/chain_code_decoder.sv
// Chain-code decoder: clears the frame RAM, plots the start pixel, then walks
// one pixel per accepted code and writes a 1 at every visited location.
module chain_code_decoder
   import chain_code_pkg::*;
#(
   parameter int IMG_W = 64,
   parameter int IMG_H = 64,
   parameter int AW    = $clog2(IMG_W*IMG_H),
   parameter int XW    = $clog2(IMG_W),
   parameter int YW    = $clog2(IMG_H)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [XW-1:0] start_x,
   input  logic [YW-1:0] start_y,
   input  logic [2:0]    code,
   input  logic          code_valid,
   input  logic          code_last,
   output logic          code_ready,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic          wr_data,
   output logic          busy,
   output logic          done,
   output logic          error
);

   localparam logic [AW-1:0] LAST_ADDR  = AW'(IMG_W*IMG_H - 1);
   localparam logic [AW-1:0] ROW_STRIDE = AW'(IMG_W);

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [XW-1:0] x_q, x_d, step_x;
   logic [YW-1:0] y_q, y_d, step_y;
   logic          step_oob;
   logic          wr_en_d, wr_data_d, busy_d, done_d, error_d;
   logic [AW-1:0] wr_addr_d;

   // Row-major address; a power-of-two stride reduces to a shift
   function automatic logic [AW-1:0] pixel_addr(input logic [XW-1:0] px,
                                                 input logic [YW-1:0] py);
      return AW'(py) * ROW_STRIDE + AW'(px);
   endfunction

   chain_code_step #(
      .IMG_W(IMG_W),
      .IMG_H(IMG_H),
      .XW   (XW),
      .YW   (YW)
   ) u_step (
      .x     (x_q),
      .y     (y_q),
      .code  (code),
      .next_x(step_x),
      .next_y(step_y),
      .oob   (step_oob)
   );

   assign code_ready = (state_q == RUN);

   // NOTE: every variable gets a default first so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      x_d       = x_q;
      y_d       = y_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr;
      wr_data_d = wr_data;
      done_d    = 1'b0;
      error_d   = error;

      case (state_q)
         IDLE: begin
            if (start) begin
               x_d     = start_x;
               y_d     = start_y;
               error_d = 1'b0;
               if ((32'(start_x) >= IMG_W) || (32'(start_y) >= IMG_H)) begin
                  error_d = 1'b1;
                  state_d = FIN;
               end else begin
                  // Address 0 is written straight away; cnt holds the next one
                  wr_en_d   = 1'b1;
                  wr_addr_d = '0;
                  wr_data_d = 1'b0;
                  cnt_d     = AW'(1);
                  state_d   = CLEAR;
               end
            end
         end

         CLEAR: begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q;
            wr_data_d = 1'b0;
            if (cnt_q == LAST_ADDR) state_d = PLOT;
            else                    cnt_d   = cnt_q + AW'(1);
         end

         PLOT: begin
            wr_en_d   = 1'b1;
            wr_addr_d = pixel_addr(x_q, y_q);
            wr_data_d = 1'b1;
            state_d   = RUN;
         end

         RUN: begin
            if (code_valid) begin
               if (step_oob) begin
                  error_d = 1'b1;
                  state_d = FIN;
               end else begin
                  x_d       = step_x;
                  y_d       = step_y;
                  wr_en_d   = 1'b1;
                  wr_addr_d = pixel_addr(step_x, step_y);
                  wr_data_d = 1'b1;
                  if (code_last) state_d = FIN;
               end
            end
         end

         FIN: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         error   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         wr_en   <= wr_en_d;
         wr_addr <= wr_addr_d;
         wr_data <= wr_data_d;
         busy    <= busy_d;
         done    <= done_d;
         error   <= error_d;
      end
   end

endmodule

// File: tb/tb_chain_code_decoder.sv
// Self-checking bench for chain_code_decoder on an 8x8 image; coordinate ports
// are 4 bits wide so that out-of-image start positions can be driven.
module tb_chain_code_decoder;

   localparam int W  = 8;
   localparam int H  = 8;
   localparam int XW = 4;
   localparam int YW = 4;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [XW-1:0] start_x;
   logic [YW-1:0] start_y;
   logic [2:0]    code;
   logic          code_valid, code_last;
   logic          code_ready, wr_en, wr_data, busy, done, error;
   logic [AW-1:0] wr_addr;

   chain_code_decoder #(
      .IMG_W(W), .IMG_H(H), .AW(AW), .XW(XW), .YW(YW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .start_x   (start_x),
      .start_y   (start_y),
      .code      (code),
      .code_valid(code_valid),
      .code_last (code_last),
      .code_ready(code_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Freeman unit steps, y downward
   int dx_tab[8] = '{1, 1, 0, -1, -1, -1, 0, 1};
   int dy_tab[8] = '{0, -1, -1, -1, 0, 1, 1, 1};

   int code_q[$];
   int obs_c[$], obs_a[$], obs_d[$];
   int acc_c[$], acc_k[$], acc_l[$];
   int rdy[$];

   task automatic cmp(input string name, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Drives one complete decode and checks it against the reference walk.
   // vmode: 0 = valid every cycle, 1 = every other cycle, 2 = random.
   task automatic run_decode(input string name, input int sx, input int sy,
                             input int vmode, input bit poke);
      int done_c, done_n, first_ready, lo, hi, a_last, x, y, nx, ny, n_used;
      bit bad, exp_err, finished;
      int exp_c[$], exp_a[$], exp_d[$];

      obs_c.delete(); obs_a.delete(); obs_d.delete();
      acc_c.delete(); acc_k.delete(); acc_l.delete(); rdy.delete();
      bad = (sx >= W) || (sy >= H);

      @(negedge clk);
      start = 1'b1; start_x = XW'(sx); start_y = YW'(sy);
      code_valid = 1'b0; code_last = 1'b0;
      done_c = -1; done_n = 0; first_ready = -1; finished = 1'b0;

      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 1) cmp({name, " error_after_start"}, int'(error), bad ? 1 : 0);
         if (wr_en) begin
            obs_c.push_back(c); obs_a.push_back(int'(wr_addr)); obs_d.push_back(int'(wr_data));
         end
         if (done) begin
            done_n++;
            if (done_c < 0) done_c = c;
         end
         rdy.push_back(int'(code_ready));
         if (code_ready && first_ready < 0) first_ready = c;
         if (poke && c == 66) begin
            start = 1'b1; start_x = '0; start_y = '0;
         end
         if (code_q.size() > 0 &&
             (vmode == 0 || (vmode == 1 && c % 2 == 0) ||
              (vmode == 2 && $urandom_range(1, 0) == 1))) begin
            code_valid = 1'b1;
            code       = 3'(code_q[0]);
            code_last  = (code_q.size() == 1);
         end else begin
            code_valid = 1'b0;
            code_last  = 1'b0;
            code       = 3'($urandom);
         end
         if (code_valid && code_ready) begin
            acc_c.push_back(c);
            acc_k.push_back(code_q[0]);
            acc_l.push_back(code_q.size() == 1 ? 1 : 0);
            void'(code_q.pop_front());
         end
         if (done_c > 0 && c >= done_c + 2) begin
            finished = 1'b1;
            break;
         end
      end
      code_valid = 1'b0; code_last = 1'b0;
      code_q.delete();
      cmp({name, " finished_in_budget"}, int'(finished), 1);

      // Reference walk
      lo = -1; hi = -1; a_last = -1; n_used = 0;
      if (bad) begin
         exp_err = 1'b1; lo = 1; hi = 2;
      end else begin
         exp_err = 1'b0;
         for (int i = 0; i < W*H; i++) begin
            exp_c.push_back(i + 1); exp_a.push_back(i); exp_d.push_back(0);
         end
         exp_c.push_back(W*H + 1); exp_a.push_back(sy*W + sx); exp_d.push_back(1);
         x = sx; y = sy;
         for (int i = 0; i < acc_c.size(); i++) begin
            n_used = i + 1;
            a_last = acc_c[i];
            nx = x + dx_tab[acc_k[i]];
            ny = y + dy_tab[acc_k[i]];
            if (nx < 0 || nx >= W || ny < 0 || ny >= H) begin
               exp_err = 1'b1; lo = acc_c[i] + 1; hi = acc_c[i] + 2;
               break;
            end
            x = nx; y = ny;
            exp_c.push_back(acc_c[i] + 1); exp_a.push_back(y*W + x); exp_d.push_back(1);
            if (acc_l[i] == 1) begin
               lo = acc_c[i] + 2; hi = lo;
               break;
            end
         end
         cmp({name, " codes_accepted"}, acc_c.size(), n_used);
         cmp({name, " first_ready_cycle"}, first_ready, W*H + 1);
         for (int c = W*H + 1; c <= a_last; c++)
            cmp({name, " ready_held"}, rdy[c-1], 1);
      end

      cmp({name, " write_count"}, obs_c.size(), exp_c.size());
      for (int i = 0; i < exp_c.size() && i < obs_c.size(); i++) begin
         cmp({name, " write_cycle"}, obs_c[i], exp_c[i]);
         cmp({name, " write_addr"},  obs_a[i], exp_a[i]);
         cmp({name, " write_data"},  obs_d[i], exp_d[i]);
      end
      cmp({name, " done_pulses"}, done_n, 1);
      cmp({name, " done_in_window"}, int'(done_c >= lo && done_c <= hi && lo > 0), 1);
      cmp({name, " error_final"}, int'(error), int'(exp_err));
      cmp({name, " busy_final"}, int'(busy), 0);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      cmp("reset_outputs", int'({code_ready, wr_en, wr_addr, wr_data, busy, done, error}), 0);
      reset = 1'b0;
   endtask

   task automatic test_reset_mid_clear;
      bit hit;
      hit = 1'b0;
      @(negedge clk);
      start = 1'b1; start_x = 4'd2; start_y = 4'd2;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (wr_en && wr_addr == 6'd20) begin
            hit = 1'b1;
            break;
         end
      end
      cmp("mid_clear_reached_20", int'(hit), 1);
      reset = 1'b1;
      #1;
      cmp("mid_clear_reset_outputs",
          int'({code_ready, wr_en, wr_addr, wr_data, busy, done, error}), 0);
      @(negedge clk);
      reset = 1'b0;
      code_q = '{6};
      run_decode("reclear", 2, 2, 0, 1'b0);
   endtask

   task automatic test_square;
      code_q = '{0, 6, 4, 2};
      run_decode("square", 3, 3, 0, 1'b0);
   endtask

   task automatic test_oob_code;
      code_q = '{3};
      run_decode("oob_code", 0, 0, 0, 1'b0);
      repeat (3) @(negedge clk);
      cmp("oob_error_sticky", int'(error), 1);
   endtask

   task automatic test_toggle_valid;
      code_q = '{3, 3};
      run_decode("toggle_valid", 7, 7, 1, 1'b0);
   endtask

   task automatic test_start_in_run;
      code_q = '{0, 0, 6, 6, 4, 2};
      run_decode("start_in_run", 4, 4, 0, 1'b1);
   endtask

   task automatic test_bad_start;
      run_decode("bad_start", 9, 0, 0, 1'b0);
   endtask

   task automatic test_random;
      int len;
      for (int it = 0; it < 8; it++) begin
         code_q.delete();
         len = $urandom_range(10, 1);
         for (int k = 0; k < len; k++) code_q.push_back($urandom_range(7, 0));
         run_decode($sformatf("random%0d", it), $urandom_range(W-1, 0),
                    $urandom_range(H-1, 0), 2, 1'b0);
      end
   endtask

   initial begin
      start = 1'b0; start_x = '0; start_y = '0;
      code = '0; code_valid = 1'b0; code_last = 1'b0;
      test_reset();
      test_reset_mid_clear();
      test_square();
      test_oob_code();
      test_toggle_valid();
      test_start_in_run();
      test_bad_start();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
